// File: rtl/ccff_chain_mem.sv
// Double-buffered configuration chain: serial shift register plus committed shadow copy.
// Optional even-parity tail stage is enabled by defining CCFF_PARITY_EN.
module ccff_chain_mem #(
  parameter int                     MEM_WIDTH = 16,
  parameter logic [0:MEM_WIDTH-1]   RESET_VAL = '0
) (
  input  logic                   prog_clk,
  input  logic                   prog_reset,
  input  logic                   ccff_head,
  input  logic                   ccff_shift_en,
  input  logic                   ccff_commit,
  output logic                   ccff_tail,
  output logic [0:MEM_WIDTH-1]   mem_out,
  output logic                   cfg_loaded,
  output logic                   cfg_err
);

`ifdef CCFF_PARITY_EN
  localparam int CHAIN_LEN = MEM_WIDTH + 1;
`else
  localparam int CHAIN_LEN = MEM_WIDTH;
`endif

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CHAIN_LEN);

  logic [0:CHAIN_LEN-1] sreg_q, sreg_d;
  logic [0:MEM_WIDTH-1] mem_q, mem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 loaded_q, loaded_d;
  logic                 err_q, err_d;
  logic                 par_ok;
  logic                 do_commit;

  // Parity covers every chain stage; without the parity stage it always passes.
`ifdef CCFF_PARITY_EN
  assign par_ok = ~(^sreg_q);
`else
  assign par_ok = 1'b1;
`endif

  // A commit only counts while the chain is not shifting in the same cycle.
  assign do_commit = ccff_commit & ~ccff_shift_en;

  // Next-state logic for chain, shift counter, shadow copy and status flags.
  always_comb begin
    sreg_d   = sreg_q;
    mem_d    = mem_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    err_d    = err_q;
    if (ccff_shift_en) begin
      sreg_d[0] = ccff_head;
      for (int i = 1; i < CHAIN_LEN; i++) begin
        sreg_d[i] = sreg_q[i-1];
      end
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (do_commit) begin
      cnt_d = '0;
      if (cnt_q == CNT_MAX && par_ok) begin
        mem_d    = sreg_q[0:MEM_WIDTH-1];
        loaded_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      sreg_q   <= '0;
      mem_q    <= RESET_VAL;
      cnt_q    <= '0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sreg_q   <= sreg_d;
      mem_q    <= mem_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail  = sreg_q[CHAIN_LEN-1];
  assign mem_out    = mem_q;
  assign cfg_loaded = loaded_q;
  assign cfg_err    = err_q;

endmodule
